// File: rtl/vip_ctrl_pkg.sv
// Shared types and constants for the VIP line-shift sequencer.
package vip_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StActive,
        StGap,
        StFlush,
        StDone
    } state_t;

    // Bit positions inside edge_flags = {top, bottom, left, right}.
    localparam int EDGE_TOP    = 3;
    localparam int EDGE_BOTTOM = 2;
    localparam int EDGE_LEFT   = 1;
    localparam int EDGE_RIGHT  = 0;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth register pipeline with synchronous reset.
module sig_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/line_shift_ctrl.sv
// Frame sequencer for the 3x3 line-shift RAM: drives RAM strobes, injects a zero flush
// line after the last input line and produces sync/valid/border flags at the matrix centre.
module line_shift_ctrl
    import vip_ctrl_pkg::*;
#(
    parameter int unsigned IMG_HDISP = 640,
    parameter int unsigned IMG_VDISP = 480,
    parameter int unsigned OUT_DLY   = 5,
    parameter int unsigned FLUSH_GAP = 16
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    output logic       ram_href,
    output logic       ram_clken,
    output logic       pad_sel,
    output logic       matrix_frame_vsync,
    output logic       matrix_frame_href,
    output logic       matrix_frame_clken,
    output logic [3:0] edge_flags,
    output logic       err_hlen,
    output logic       err_overrun
);

    localparam int unsigned PW = cnt_width(IMG_HDISP + 1);
    localparam int unsigned LW = cnt_width(IMG_VDISP);
    localparam int unsigned GW = cnt_width(FLUSH_GAP);
    localparam int unsigned FW = cnt_width(IMG_HDISP);

    localparam logic [PW-1:0] PIX_SAT    = PW'(IMG_HDISP + 1);
    localparam logic [PW-1:0] PIX_FULL   = PW'(IMG_HDISP);
    localparam logic [PW-1:0] PIX_LAST   = PW'(IMG_HDISP - 1);
    localparam logic [LW-1:0] LINE_MAX   = LW'(IMG_VDISP);
    localparam logic [LW-1:0] LINE_LAST  = LW'(IMG_VDISP - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(FLUSH_GAP - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_HDISP - 1);

    state_t        state;
    logic          vsync_q;
    logic          href_q;
    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;
    logic [GW-1:0] gap_cnt;
    logic [FW-1:0] flush_cnt;

    // RAM-side qualified signals, aligned with ram_clken, fed into the output pipeline.
    logic          ram_vsync;
    logic          q_href;
    logic          q_clken;
    logic [3:0]    q_flags;
    logic [6:0]    dly_out;

    logic          vs_rise;
    logic          href_fall;
    logic          pixel;
    logic          start;
    logic          in_active;
    logic [PW-1:0] cur_pix;
    logic [LW-1:0] cur_line;

    always_comb begin
        vs_rise   = per_frame_vsync && !vsync_q;
        href_fall = href_q && !per_frame_href;
        pixel     = per_frame_href && per_frame_clken;
        start     = (state == StIdle) && vs_rise;
        // The vsync-rise cycle already counts as ACTIVE so a coincident first pixel is kept.
        in_active = start || ((state == StActive) && per_frame_vsync);
        cur_pix   = start ? '0 : pix_cnt;
        cur_line  = start ? '0 : line_cnt;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= StIdle;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            gap_cnt     <= '0;
            flush_cnt   <= '0;
            ram_href    <= 1'b0;
            ram_clken   <= 1'b0;
            pad_sel     <= 1'b0;
            ram_vsync   <= 1'b0;
            q_href      <= 1'b0;
            q_clken     <= 1'b0;
            q_flags     <= '0;
            err_hlen    <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            vsync_q   <= per_frame_vsync;
            href_q    <= per_frame_href;
            ram_href  <= 1'b0;
            ram_clken <= 1'b0;
            pad_sel   <= 1'b0;
            ram_vsync <= 1'b0;
            q_href    <= 1'b0;
            q_clken   <= 1'b0;
            q_flags   <= '0;

            unique case (state)
                StIdle: begin
                    if (vs_rise) begin
                        pix_cnt     <= '0;
                        line_cnt    <= '0;
                        gap_cnt     <= '0;
                        flush_cnt   <= '0;
                        err_hlen    <= 1'b0;
                        err_overrun <= 1'b0;
                        state       <= StActive;
                    end
                end
                StActive: begin
                    if (!per_frame_vsync) begin
                        state <= StIdle;
                    end else if (href_fall) begin
                        if (pix_cnt != PIX_FULL) err_hlen <= 1'b1;
                        pix_cnt <= '0;
                        if (line_cnt != LINE_MAX) line_cnt <= line_cnt + LW'(1);
                        if (line_cnt == LINE_LAST) state <= StGap;
                    end
                end
                StGap: begin
                    ram_vsync <= 1'b1;
                    if (per_frame_href || per_frame_clken) err_overrun <= 1'b1;
                    if (gap_cnt == GAP_LAST) state <= StFlush;
                    else gap_cnt <= gap_cnt + GW'(1);
                end
                StFlush: begin
                    ram_vsync <= 1'b1;
                    ram_href  <= 1'b1;
                    ram_clken <= 1'b1;
                    pad_sel   <= 1'b1;
                    q_href    <= 1'b1;
                    q_clken   <= 1'b1;
                    // Flush line carries centre row IMG_VDISP-1.
                    q_flags[EDGE_TOP]    <= (IMG_VDISP == 1);
                    q_flags[EDGE_BOTTOM] <= 1'b1;
                    q_flags[EDGE_LEFT]   <= (flush_cnt == '0);
                    q_flags[EDGE_RIGHT]  <= (flush_cnt == FLUSH_LAST);
                    if (per_frame_href || per_frame_clken) err_overrun <= 1'b1;
                    if (flush_cnt == FLUSH_LAST) state <= StDone;
                    else flush_cnt <= flush_cnt + FW'(1);
                end
                StDone: begin
                    if (!per_frame_vsync) state <= StIdle;
                end
                default: state <= StIdle;
            endcase

            if (in_active) begin
                ram_vsync <= 1'b1;
                ram_href  <= per_frame_href;
                ram_clken <= pixel;
                // RAM line 0 has no valid centre row yet.
                q_href    <= per_frame_href && (cur_line != '0);
                q_clken   <= pixel && (cur_line != '0);
                if (pixel) begin
                    if (cur_pix != PIX_SAT) pix_cnt <= cur_pix + PW'(1);
                    if (cur_line != '0) begin
                        q_flags[EDGE_TOP]    <= (cur_line == LW'(1));
                        q_flags[EDGE_BOTTOM] <= (cur_line == LINE_MAX);
                        q_flags[EDGE_LEFT]   <= (cur_pix == '0);
                        q_flags[EDGE_RIGHT]  <= (cur_pix == PIX_LAST);
                    end
                end
            end
        end
    end

    sig_delay #(
        .WIDTH (7),
        .DEPTH (OUT_DLY)
    ) u_out_dly (
        .clock (clock),
        .rst   (rst),
        .din   ({ram_vsync, q_href, q_clken, q_flags}),
        .dout  (dly_out)
    );

    assign {matrix_frame_vsync, matrix_frame_href, matrix_frame_clken, edge_flags} = dly_out;

endmodule

// File: doc/line_shift_ctrl.md
# line_shift_ctrl

Frame sequencer for the 3x3 line-shift RAM datapath in the VIP matrix chain. Tracks pixel/line position of the incoming video stream and drives the RAM's `clken` and `pre_frame_href`. After the last input line it injects one synthetic zero line so the bottom image row reaches the window centre. Emits sync, valid and border flags aligned with the 3x3 matrix output.

## Interface
Parameters:
- `IMG_HDISP`, 640, active pixels per line
- `IMG_VDISP`, 480, active lines per frame
- `OUT_DLY`, 5, cycles from RAM input to matrix centre output (3 RAM + 2 column shift)
- `FLUSH_GAP`, 16, idle cycles between the last line's `href` fall and the flush line

Ports:
- `clock`  in  1  single system clock
- `rst`  in  1  synchronous, active-high reset
- `per_frame_vsync`  in  1  frame sync, high for the whole frame
- `per_frame_href`  in  1  line valid
- `per_frame_clken`  in  1  pixel strobe
- `ram_href`  out  1  drives the line-shift RAM `pre_frame_href`
- `ram_clken`  out  1  drives the line-shift RAM `clken`
- `pad_sel`  out  1  1 = RAM data mux selects 8'h00 (flush line)
- `matrix_frame_vsync`  out  1  vsync aligned to matrix output
- `matrix_frame_href`  out  1  output line valid
- `matrix_frame_clken`  out  1  output pixel valid
- `edge_flags`  out  4  {top, bottom, left, right} border of the centre pixel
- `err_hlen`  out  1  sticky: an input line ≠ IMG_HDISP pixels
- `err_overrun`  out  1  sticky: input activity during FLUSH

## Operation
- States: IDLE, ACTIVE, GAP, FLUSH, DONE.
- IDLE: wait for the `per_frame_vsync` rising edge, then clear counters and both error flags and go to ACTIVE.
- ACTIVE: `ram_href`/`ram_clken` pass through from the inputs. `pix_cnt` counts clken within a line. On `href` fall: check `pix_cnt == IMG_HDISP` (else set `err_hlen`), increment `line_cnt`, clear `pix_cnt`. When `line_cnt` reaches IMG_VDISP, go to GAP. Lines beyond IMG_VDISP never reach the RAM.
- GAP: hold `ram_href=0` for FLUSH_GAP cycles, then go to FLUSH.
- FLUSH: `ram_href=1`, `ram_clken=1`, `pad_sel=1` for exactly IMG_HDISP consecutive cycles, then go to DONE.
- DONE: wait for `per_frame_vsync` low, then IDLE.
- Input `href`/`clken` in GAP or FLUSH: ignored; sets `err_overrun`. Flush still completes.
- Vsync fall in ACTIVE: abort to IDLE; no flush.
- Output validity: RAM line k has centre row k-1. The output `href`/`clken` are suppressed for RAM line 0. RAM lines 1..IMG_VDISP (the last is the flush line) form IMG_VDISP output lines.
- Edge flags for the centre pixel:
  - top: row 0
  - bottom: row IMG_VDISP-1
  - left: column 0
  - right: column IMG_HDISP-1
- Counters are sized to `$clog2(max+1)` and saturate, never wrap. `pix_cnt` saturates at IMG_HDISP+1 so overlong lines are still detected.

## Timing
- Reset: all outputs 0; state IDLE; counters 0; delay lines flushed to 0.
- `ram_href`/`ram_clken`/`pad_sel` are registered: one cycle after the input (ACTIVE) or state change (FLUSH).
- `matrix_*` and `edge_flags` = RAM-side signals delayed `OUT_DLY` cycles through one shift pipeline. Qualification and edge flags are computed at RAM-side time.
- `matrix_frame_vsync` falls `OUT_DLY` cycles after the last flush clken, not after the input vsync fall.
- Reset mid-frame: immediate return to IDLE. The next vsync rising edge starts a clean frame.
- Vsync rise and href rise on the same cycle: the pixel is counted in ACTIVE.

## Structure
- Package `vip_ctrl_pkg`: state enum, `EDGE_TOP/BOTTOM/LEFT/RIGHT` bit-index constants, counter width helper.
- Sub-module `sig_delay`: parameterised width × depth register pipeline with synchronous reset. Instantiated once, for {vsync, href, clken, edge_flags}.
- Zero-pad mux and RAM instance live in the parent; this block only drives `pad_sel`.

## Test plan
- 8×4 frame (IMG_HDISP=8, IMG_VDISP=4), continuous clken, gap 4 -> RAM sees 5 lines of 8; output has 4 lines × 8 `clken`. `edge_flags` = 4'b1010 on the first pixel and 4'b0101 on the last. No errors.
- Line 2 only 7 pixels -> `err_hlen`=1 after that line; flag stays set until the next vsync rise, then clears.
- `href` pulse during FLUSH -> `err_overrun`=1; flush still emits exactly 8 `ram_clken` with `pad_sel`=1.
- 6 input lines with IMG_VDISP=4 -> lines 5–6 produce no `ram_clken`; output is still 4 lines.
- `rst` asserted mid-line 2 -> next cycle all outputs 0, state IDLE; the following frame is fully correct.
- Gappy clken (every other cycle) -> output `clken` count per line is 8, and each output pulse is `OUT_DLY` cycles after its RAM-side pulse.
